esm_issue_scheduler: RTL and testbench
======================================

// Module: esm_issue_scheduler
// PURPOSE
//  Slot allocator and issue scheduler for the ESM instruction-dependency analyser (IDA).
//  Accepts decoded instructions over a valid/ready handshake and stores each in a free slot of a bs-entry buffer.
//  Writes every accepted instruction into the IDA and maintains the valid_entries vector the IDA needs.
//  Uses the IDA's independent_instr vector to issue independent instructions round-robin over an output handshake.
// PARAMETERS
//  Instruction_word_size  32  width of an instruction word
//  bs                     16  buffer slots; power of 2, >= 2
//  IDA_LAT                2   cycles from an IDA write until that slot's independent_instr bit is valid
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      asynchronous, active-high reset
//  flush          in   1      synchronous: drop all buffered and pending instructions
//  in_valid       in   1      instruction offered
//  in_ready       out  1      free slot available (combinational from registered state: not full and not flush)
//  in_instr       in   IWS    instruction word
//  in_regwrite    in   1      instruction writes rd
//  in_alusrc      in   1      instruction uses an immediate (rs2 unused)
//  ida_we         out  1      IDA row written this cycle
//  ida_index      out  log2bs slot being written (buffer_index of the IDA)
//  ida_instr      out  IWS    instruction to the IDA (Instr_in)
//  ida_regwrite   out  1      RegWrite to the IDA
//  ida_alusrc     out  1      ALUSrc to the IDA
//  valid_entries  out  bs     occupancy bitmap, bit i = slot i (MSB-first [0:bs-1], matching the IDA)
//  independent_instr in bs    from the IDA
//  issue_valid    out  1      issue register holds an instruction
//  issue_ready    in   1      consumer accepts
//  issue_instr    out  IWS    issued instruction word
//  issue_index    out  log2bs slot it came from
//  occupancy      out  log2bs+1  number of set valid_entries bits
// BEHAVIOUR
//  Reset: all outputs 0, including every slot, wait counter and payload; RR pointer = 0.
//  Alloc: accept on in_valid&&in_ready (cycle T). Slot = lowest-index clear bit of valid_entries as registered at T.
//    At edge T+1: set valid bit, store payload, load the slot's wait counter with IDA_LAT.
//    Drive ida_we=1, ida_index, ida_instr, ida_regwrite and ida_alusrc as registers during T+1.
//  Idle write port: ida_we=0 and the ida_* registers hold their last values, so a repeated write to the same row is idempotent.
//  Wait counter: decrements to 0 once per cycle. A slot is eligible when valid && counter==0 && independent_instr[i].
//  Issue register: loads when !issue_valid || issue_ready.
//    Loads the first eligible slot at or after the RR pointer, wrapping at bs.
//    On load: valid bit clears at the same edge, RR pointer = slot+1 mod bs, issue_valid=1.
//    If nothing is eligible, issue_valid=0 once the held instruction has been taken.
//  Output stability: while issue_valid && !issue_ready, issue_instr and issue_index stay stable. No selection occurs.
//  Same-cycle alloc and issue: a slot freed at edge E is allocatable from cycle E onward, never in the same cycle.
//    occupancy = popcount(valid_entries), which reflects both events.
//  Full: in_ready=0 when all bs bits are set. in_valid is ignored (no drop, no overwrite).
//  Flush: at the next edge all valid bits, wait counters, issue_valid and ida_we clear. in_ready=0 during the flush cycle.
//    Flush has priority over alloc and issue; a concurrent issue_ready handshake is lost.
//  Reset mid-operation: asynchronous clear to the reset state. No handshake completes in that cycle.
// STRUCTURE
//  Package esm_pkg: slot index width log2(bs), ESM_IDA_LAT default, the {instr, regwrite, alusrc} slot payload struct/width.
//  Sub-module esm_rr_picker: bs-wide round-robin priority picker (request vector and pointer in; one-hot grant and index out).
//    The same picker, with the pointer tied to 0, implements the lowest-free allocator.
//  Payload array: flops, bs x IWS. No RAM macro needed.
// TESTING
//  1) Reset, then 3 accepts with in_valid held 1 -> slots 0,1,2; ida_we high on cycles 1..3; valid_entries=1110_0..0; occupancy=3.
//  2) Accept into slot 0 with independent_instr[0]=1 tied high -> issue_valid rises exactly IDA_LAT+1 cycles after ida_we; issue_index=0.
//  3) Slots 0..3 valid and eligible, issue_ready=1 -> issue order 0,1,2,3, one per cycle. Refill slot 0 -> next issue is slot 0 (wrap).
//  4) Fill 16 slots with issue_ready=0 -> in_ready=0 and a 17th in_valid is held off. Raise issue_ready for 1 cycle -> in_ready=1 next cycle; new instr goes to the freed slot.
//  5) Held stall: issue_ready=0 for 5 cycles with the issue register full -> issue_instr/index unchanged, no valid bit clears.
//  6) flush during a simultaneous accept and issue -> next cycle valid_entries=0, occupancy=0, issue_valid=0, ida_we=0. Async rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared types and defaults for the ESM issue scheduler slice.
package esm_pkg;

  localparam int unsigned ESM_IWS     = 32;
  localparam int unsigned ESM_BS      = 16;
  localparam int unsigned ESM_IDX_W   = $clog2(ESM_BS);
  localparam int unsigned ESM_IDA_LAT = 2;

  typedef struct packed {
    logic [ESM_IWS-1:0] instr;
    logic               regwrite;
    logic               alusrc;
  } esm_payload_t;

  localparam int unsigned ESM_PAYLOAD_W = $bits(esm_payload_t);

endpackage

// File: rtl/esm_rr_picker.sv
// Round-robin priority picker: first request at or after ptr, wrapping at N.
// N must be a power of two so the candidate index wraps for free.
module esm_rr_picker
  import esm_pkg::*;
#(
  parameter int unsigned N    = ESM_BS,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [IDXW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IDXW'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/esm_issue_scheduler.sv
// Slot allocator and round-robin issue scheduler feeding the ESM IDA.
// Slot i maps to bit i of the MSB-first valid_entries / independent_instr vectors.
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter int unsigned Instruction_word_size = ESM_IWS,
  parameter int unsigned bs                    = ESM_BS,
  parameter int unsigned IDA_LAT               = ESM_IDA_LAT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Instruction_word_size-1:0] in_instr,
  input  logic                             in_regwrite,
  input  logic                             in_alusrc,
  output logic                             ida_we,
  output logic [$clog2(bs)-1:0]            ida_index,
  output logic [Instruction_word_size-1:0] ida_instr,
  output logic                             ida_regwrite,
  output logic                             ida_alusrc,
  output logic [0:bs-1]                    valid_entries,
  input  logic [0:bs-1]                    independent_instr,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [Instruction_word_size-1:0] issue_instr,
  output logic [$clog2(bs)-1:0]            issue_index,
  output logic [$clog2(bs):0]              occupancy
);

  localparam int unsigned IDXW = $clog2(bs);
  localparam int unsigned WW   = $clog2(IDA_LAT + 2);
  localparam int unsigned OCCW = IDXW + 1;

  logic [bs-1:0]                    valid_q;
  logic [bs-1:0]                    eligible;
  logic [bs-1:0]                    alloc_gnt;
  logic [bs-1:0]                    issue_gnt;
  logic [WW-1:0]                    wait_q  [bs];
  logic [Instruction_word_size-1:0] instr_q [bs];
  logic [IDXW-1:0]                  rr_q;
  logic [IDXW-1:0]                  alloc_idx;
  logic [IDXW-1:0]                  issue_idx;
  logic                             alloc_any;
  logic                             issue_any;
  logic                             accept;
  logic                             load_en;
  logic                             do_issue;

  // Lowest-free allocator is the same picker with the pointer pinned at 0.
  esm_rr_picker #(.N(bs), .IDXW(IDXW)) u_alloc_pick (
    .req (~valid_q),
    .ptr ('0),
    .gnt (alloc_gnt),
    .idx (alloc_idx),
    .any (alloc_any)
  );

  esm_rr_picker #(.N(bs), .IDXW(IDXW)) u_issue_pick (
    .req (eligible),
    .ptr (rr_q),
    .gnt (issue_gnt),
    .idx (issue_idx),
    .any (issue_any)
  );

  assign in_ready = !rst && alloc_any && !flush;
  assign accept   = in_valid && in_ready;
  assign load_en  = !issue_valid || issue_ready;
  assign do_issue = load_en && issue_any;

  always_comb begin
    eligible  = '0;
    occupancy = '0;
    for (int unsigned i = 0; i < bs; i++) begin
      valid_entries[i] = valid_q[i];
      eligible[i]      = valid_q[i] && (wait_q[i] == '0) && independent_instr[i];
      occupancy        = occupancy + OCCW'(valid_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      rr_q         <= '0;
      ida_we       <= 1'b0;
      ida_index    <= '0;
      ida_instr    <= '0;
      ida_regwrite <= 1'b0;
      ida_alusrc   <= 1'b0;
      issue_valid  <= 1'b0;
      issue_instr  <= '0;
      issue_index  <= '0;
      for (int unsigned i = 0; i < bs; i++) begin
        wait_q[i]  <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q     <= '0;
      ida_we      <= 1'b0;
      issue_valid <= 1'b0;
      for (int unsigned i = 0; i < bs; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      ida_we <= accept;
      if (accept) begin
        ida_index    <= alloc_idx;
        ida_instr    <= in_instr;
        ida_regwrite <= in_regwrite;
        ida_alusrc   <= in_alusrc;
      end
      for (int unsigned i = 0; i < bs; i++) begin
        if (accept && alloc_gnt[i]) begin
          wait_q[i]  <= WW'(IDA_LAT);
          instr_q[i] <= in_instr;
        end else if (wait_q[i] != '0) begin
          wait_q[i] <= wait_q[i] - WW'(1);
        end
      end
      // Alloc targets a clear bit and issue a set bit, so the two masks never overlap.
      valid_q <= (valid_q | ({bs{accept}} & alloc_gnt)) & ~({bs{do_issue}} & issue_gnt);
      if (load_en) begin
        issue_valid <= issue_any;
        if (issue_any) begin
          issue_instr <= instr_q[issue_idx];
          issue_index <= issue_idx;
          rr_q        <= issue_idx + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Self-checking bench for esm_issue_scheduler: directed table, corner sequences, random vs model.
module tb_esm_issue_scheduler;

  localparam int IWS = 32;
  localparam int BS  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic          in_regwrite;
  logic          in_alusrc;
  logic          ida_we;
  logic [3:0]    ida_index;
  logic [31:0]   ida_instr;
  logic          ida_regwrite;
  logic          ida_alusrc;
  logic [0:15]   valid_entries;
  logic [0:15]   independent_instr;
  logic          issue_valid;
  logic          issue_ready;
  logic [31:0]   issue_instr;
  logic [3:0]    issue_index;
  logic [4:0]    occupancy;

  esm_issue_scheduler #(
    .Instruction_word_size(IWS),
    .bs(BS),
    .IDA_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_regwrite(in_regwrite), .in_alusrc(in_alusrc),
    .ida_we(ida_we), .ida_index(ida_index), .ida_instr(ida_instr),
    .ida_regwrite(ida_regwrite), .ida_alusrc(ida_alusrc),
    .valid_entries(valid_entries), .independent_instr(independent_instr),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_index(issue_index),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slot table with write timestamps instead of counters.
  bit          m_valid [BS];
  int          m_wcyc  [BS];
  logic [31:0] m_instr [BS];
  int          m_rr;
  bit          m_iv;
  logic [31:0] m_iinstr;
  int          m_iidx;
  bit          m_we;
  int          m_ida_idx;
  logic [31:0] m_ida_instr;
  bit          m_ida_rw;
  bit          m_ida_as;
  int          m_cyc;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < BS; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BS; i++) begin
      m_valid[i] = 0;
      m_wcyc[i]  = 0;
      m_instr[i] = '0;
    end
    m_rr = 0; m_iv = 0; m_iinstr = '0; m_iidx = 0;
    m_we = 0; m_ida_idx = 0; m_ida_instr = '0; m_ida_rw = 0; m_ida_as = 0;
    m_cyc = 0;
  endtask

  task automatic model_update();
    int  free_slot = -1;
    int  pick = -1;
    bit  acc;
    if (flush) begin
      for (int i = 0; i < BS; i++) m_valid[i] = 0;
      m_iv = 0;
      m_we = 0;
    end else begin
      for (int i = BS - 1; i >= 0; i--) if (!m_valid[i]) free_slot = i;
      acc = in_valid && (free_slot >= 0);
      if (!m_iv || issue_ready) begin
        for (int k = 0; k < BS; k++) begin
          int s = (m_rr + k) % BS;
          if (pick < 0 && m_valid[s] && (m_cyc - m_wcyc[s] >= LAT) && independent_instr[s] === 1'b1)
            pick = s;
        end
        if (pick >= 0) begin
          m_iv = 1; m_iinstr = m_instr[pick]; m_iidx = pick;
          m_valid[pick] = 0; m_rr = (pick + 1) % BS;
        end else begin
          m_iv = 0;
        end
      end
      m_we = acc;
      if (acc) begin
        m_valid[free_slot] = 1;
        m_wcyc[free_slot]  = m_cyc + 1;
        m_instr[free_slot] = in_instr;
        m_ida_idx = free_slot; m_ida_instr = in_instr;
        m_ida_rw = in_regwrite; m_ida_as = in_alusrc;
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    logic [0:15] exp_ve;
    for (int i = 0; i < BS; i++) exp_ve[i] = m_valid[i];
    chk("valid_entries", 64'(valid_entries), 64'(exp_ve));
    chk("occupancy", 64'(occupancy), 64'(m_count()));
    chk("issue_valid", 64'(issue_valid), 64'(m_iv));
    chk("issue_index", 64'(issue_index), 64'(m_iidx));
    chk("issue_instr", 64'(issue_instr), 64'(m_iinstr));
    chk("ida_we", 64'(ida_we), 64'(m_we));
    chk("ida_index", 64'(ida_index), 64'(m_ida_idx));
    chk("ida_payload", 64'({ida_instr, ida_regwrite, ida_alusrc}), 64'({m_ida_instr, m_ida_rw, m_ida_as}));
  endtask

  // Caller drives inputs just after a rising edge; one call = one clock.
  task automatic step();
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'((m_count() < BS) && !flush));
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic ir, input logic [15:0] ind, input logic fl);
    in_valid = v; in_instr = ins; in_regwrite = ins[0]; in_alusrc = ins[1];
    issue_ready = ir; independent_instr = ind; flush = fl;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        ir;
    logic [15:0] ind;
    logic [0:15] eve;
    int          eocc;
    logic        eiv;
    int          eidx;
    logic        ewe;
    int          eida;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] ins, logic ir, logic [15:0] ind,
                              logic [15:0] eve, int eocc, logic eiv, int eidx, logic ewe, int eida);
    vec_t r;
    r.v = v; r.instr = ins; r.ir = ir; r.ind = ind; r.eve = eve; r.eocc = eocc;
    r.eiv = eiv; r.eidx = eidx; r.ewe = ewe; r.eida = eida;
    return r;
  endfunction

  vec_t tbl [14];

  initial begin
    logic [31:0] held_instr;
    logic [3:0]  held_idx;

    // Three accepts, four-slot round-robin drain, wrap back to slot 0, IDA latency.
    tbl[0]  = mk(1, 32'hA0, 0, 16'h0000, 16'h8000, 1, 0, 0, 1, 0);
    tbl[1]  = mk(1, 32'hA1, 0, 16'h0000, 16'hC000, 2, 0, 0, 1, 1);
    tbl[2]  = mk(1, 32'hA2, 0, 16'h0000, 16'hE000, 3, 0, 0, 1, 2);
    tbl[3]  = mk(0, 32'h0,  0, 16'h0000, 16'hE000, 3, 0, 0, 0, 0);
    tbl[4]  = mk(1, 32'hA3, 0, 16'h0000, 16'hF000, 4, 0, 0, 1, 3);
    tbl[5]  = mk(0, 32'h0,  1, 16'hFFFF, 16'h7000, 3, 1, 0, 0, 0);
    tbl[6]  = mk(0, 32'h0,  1, 16'hFFFF, 16'h3000, 2, 1, 1, 0, 0);
    tbl[7]  = mk(0, 32'h0,  1, 16'hFFFF, 16'h1000, 1, 1, 2, 0, 0);
    tbl[8]  = mk(0, 32'h0,  1, 16'hFFFF, 16'h0000, 0, 1, 3, 0, 0);
    tbl[9]  = mk(1, 32'hB0, 1, 16'hFFFF, 16'h8000, 1, 0, 0, 1, 0);
    tbl[10] = mk(0, 32'h0,  1, 16'hFFFF, 16'h8000, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 32'h0,  1, 16'hFFFF, 16'h8000, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 32'h0,  1, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 0);
    tbl[13] = mk(0, 32'h0,  1, 16'hFFFF, 16'h0000, 0, 0, 0, 0, 0);

    rst = 1'b1;
    drive(0, '0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_entries", 64'(valid_entries), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_issue", 64'({issue_valid, issue_index, issue_instr}), 64'(0));
    chk("rst_ida", 64'({ida_we, ida_index, ida_instr, ida_regwrite, ida_alusrc}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    model_reset();

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].v, tbl[k].instr, tbl[k].ir, tbl[k].ind, 0);
      step();
      chk($sformatf("tbl%0d_ve", k), 64'(valid_entries), 64'(tbl[k].eve));
      chk($sformatf("tbl%0d_occ", k), 64'(occupancy), 64'(tbl[k].eocc));
      chk($sformatf("tbl%0d_iv", k), 64'(issue_valid), 64'(tbl[k].eiv));
      if (tbl[k].eiv) chk($sformatf("tbl%0d_iidx", k), 64'(issue_index), 64'(tbl[k].eidx));
      chk($sformatf("tbl%0d_we", k), 64'(ida_we), 64'(tbl[k].ewe));
      if (tbl[k].ewe) chk($sformatf("tbl%0d_ida", k), 64'(ida_index), 64'(tbl[k].eida));
    end

    // Fill all slots with nothing independent, then hold off a 17th offer.
    for (int k = 0; k < 16; k++) begin
      drive(1, 32'hC00 + 32'(k), 0, 16'h0000, 0);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'hEEE, 0, 16'h0000, 0);
      step();
      chk("full_in_ready", 64'(in_ready), 64'(0));
      chk("full_occ", 64'(occupancy), 64'(16));
      chk("full_no_we", 64'(ida_we), 64'(0));
    end
    drive(1, 32'hEEE, 1, 16'hFFFF, 0);
    step();
    chk("free_issue_idx", 64'(issue_index), 64'(1));
    chk("free_in_ready", 64'(in_ready), 64'(1));
    drive(1, 32'hD00, 0, 16'hFFFF, 0);
    step();
    chk("refill_ida_idx", 64'(ida_index), 64'(1));
    chk("refill_occ", 64'(occupancy), 64'(16));

    // Held stall: issue register full, consumer not ready.
    held_instr = 32'hC01;
    held_idx   = 4'd1;
    for (int k = 0; k < 5; k++) begin
      drive(0, '0, 0, 16'hFFFF, 0);
      step();
      chk("stall_instr", 64'(issue_instr), 64'(held_instr));
      chk("stall_idx", 64'(issue_index), 64'(held_idx));
      chk("stall_ve", 64'(valid_entries), 64'(16'hFFFF));
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 1, 16'hFFFF, 0);
      step();
    end

    // Flush collides with an accept and an issue handshake.
    drive(1, 32'hF1, 1, 16'hFFFF, 1);
    step();
    chk("flush_ve", 64'(valid_entries), 64'(0));
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_iv", 64'(issue_valid), 64'(0));
    chk("flush_we", 64'(ida_we), 64'(0));
    drive(1, 32'hF2, 0, 16'h0000, 0);
    step();
    chk("post_flush_ida", 64'(ida_index), 64'(0));

    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6),
            16'($urandom | $urandom), ($urandom_range(0, 49) == 0));
      step();
    end

    // Asynchronous reset between edges.
    drive(1, 32'h55, 1, 16'hFFFF, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ve", 64'(valid_entries), 64'(0));
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_issue", 64'({issue_valid, issue_index, issue_instr}), 64'(0));
    chk("arst_ida", 64'({ida_we, ida_index, ida_instr, ida_regwrite, ida_alusrc}), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 60; k++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 5),
            16'($urandom | $urandom), 1'b0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
